pwm_ctrl: RTL and testbench

Configuration sequencer for the 3-channel pwm core and its IO pads. A simple register-write port fills shadow registers. A commit request transfers them to the live pwm configuration (enable_i, prescaler_i, pwm_period_i, duty_cycle_i) only at a PWM period boundary, so a period is never glitched. The block sits between the MCU peripheral bus glue and the pwm instance in top.

---
 rtl/pwm_ctrl_pkg.sv | 26 ++
 rtl/pwm_duty_ramp.sv | 100 ++++++++++
 rtl/pwm_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pwm_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared constants for the pwm configuration sequencer:
//   - register address map of the shadow register write port
//   - sequencer FSM state encoding (legacy localparam values + enum type)
// ---------------------------------------------------------------------------
package pwm_ctrl_pkg;

  // Shadow register address map
  localparam logic [3:0] ADDR_PSC   = 4'd0;  // prescaler (low PSC_W bits)
  localparam logic [3:0] ADDR_PER   = 4'd1;  // period (0 is rejected)
  localparam logic [3:0] ADDR_EN    = 4'd2;  // channel enable mask (low N_CH bits)
  localparam logic [3:0] ADDR_DUTY0 = 4'd3;  // duty of channel 0; channel i at ADDR_DUTY0+i

  // FSM encodings kept as plain constants so older code can keep comparing raw values
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PENDING = ST_PENDING,
    COMMIT  = ST_COMMIT
  } pwm_state_e;

endpackage : pwm_ctrl_pkg

// File: rtl/pwm_duty_ramp.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp
// Per-channel live duty register.
//
// Optional feature macro: PWM_CTRL_RAMP_EN
//   defined   : a commit loads a target; the live duty walks toward it by
//               RAMP_STEP on every period end (enabled channels only),
//               saturating at the target. Channels being committed with
//               enable 0 jump straight to the target.
//   undefined : a commit loads the live duty directly; no target register.
//
// Ports
//   clk        system clock
//   rstn       asynchronous active-low reset
//   load_i     commit strobe (one cycle)
//   load_val_i already clamped duty value to commit
//   load_en_i  channel enable value being committed alongside
//   en_i       current live channel enable
//   step_i     period end pulse from the pwm core
//   duty_o     live duty
//   busy_o     live duty has not yet reached its target
// ---------------------------------------------------------------------------
module pwm_duty_ramp #(
  parameter int CNT_W     = 16,
  parameter int RAMP_STEP = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             load_en_i,
  input  logic             en_i,
  input  logic             step_i,
  output logic [CNT_W-1:0] duty_o,
  output logic             busy_o
);

`ifdef PWM_CTRL_RAMP_EN

  localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

  logic [CNT_W-1:0] duty_reg, duty_next;
  logic [CNT_W-1:0] target_reg, target_next;

  always_comb begin
    duty_next   = duty_reg;
    target_next = target_reg;
    if (load_i) begin
      // A commit retargets from wherever the live value currently is.
      target_next = load_val_i;
      if (!load_en_i) begin
        duty_next = load_val_i;
      end
    end else if (!en_i) begin
      duty_next = target_reg;
    end else if (step_i) begin
      // Compare the remaining distance with the step so the walk never overshoots.
      if (duty_reg < target_reg) begin
        duty_next = ((target_reg - duty_reg) <= STEP) ? target_reg : duty_reg + STEP;
      end else if (duty_reg > target_reg) begin
        duty_next = ((duty_reg - target_reg) <= STEP) ? target_reg : duty_reg - STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_reg   <= '0;
      target_reg <= '0;
    end else begin
      duty_reg   <= duty_next;
      target_reg <= target_next;
    end
  end

  assign duty_o = duty_reg;
  assign busy_o = en_i && (duty_reg != target_reg);

`else

  logic [CNT_W-1:0] duty_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_reg <= '0;
    end else if (load_i) begin
      duty_reg <= load_val_i;
    end
  end

  assign duty_o = duty_reg;
  assign busy_o = 1'b0;

  // Ramp-only inputs; kept on the port list so the top wiring is build-independent.
  logic unused_ok;
  assign unused_ok = ^{load_en_i, en_i, step_i, RAMP_STEP[0]};

`endif

endmodule : pwm_duty_ramp

// File: rtl/pwm_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_ctrl
// Configuration sequencer for the N_CH-channel pwm core. Register writes fill
// shadow registers; a commit copies them into the live configuration, waiting
// for a period boundary when any channel is running so no period is glitched.
//
// Optional feature macro: PWM_CTRL_RAMP_EN (duty ramping, see pwm_duty_ramp)
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   cfg_valid_i   write request
//   cfg_ready_o   write accepted when valid & ready (high only in IDLE)
//   cfg_addr_i    shadow register address
//   cfg_data_i    write data
//   cfg_commit_i  single-cycle commit request
//   period_end_i  one-cycle pulse from the pwm core at each period end
//   enable_o      live channel enables
//   prescaler_o   live prescaler
//   pwm_period_o  live period
//   duty_cycle_o  live duties, channel i at [i*CNT_W +: CNT_W]
//   busy_o        commit pending or duty ramp in progress
//   err_o         one-cycle pulse the cycle after a rejected write
// ---------------------------------------------------------------------------
module pwm_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int CNT_W     = 16,
  parameter int PSC_W     = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [3:0]            cfg_addr_i,
  input  logic [CNT_W-1:0]      cfg_data_i,
  input  logic                  cfg_commit_i,
  input  logic                  period_end_i,
  output logic [N_CH-1:0]       enable_o,
  output logic [PSC_W-1:0]      prescaler_o,
  output logic [CNT_W-1:0]      pwm_period_o,
  output logic [N_CH*CNT_W-1:0] duty_cycle_o,
  output logic                  busy_o,
  output logic                  err_o
);

  pwm_state_e state_reg, state_next;

  // Shadow registers
  logic [PSC_W-1:0] psc_sh_reg;
  logic [CNT_W-1:0] per_sh_reg;
  logic [N_CH-1:0]  en_sh_reg;

  // Live registers (duties live inside the per-channel ramp instances)
  logic [PSC_W-1:0] psc_reg;
  logic [CNT_W-1:0] per_reg;
  logic [N_CH-1:0]  en_reg;
  logic             err_reg;

  logic [N_CH-1:0]  ramp_busy;

  // Write decode
  logic wr_fire;
  logic is_psc, is_per, is_en, is_duty;
  logic wr_bad, wr_ok;
  logic commit_load;

  assign cfg_ready_o = (state_reg == IDLE);
  assign wr_fire     = cfg_valid_i && cfg_ready_o;

  assign is_psc  = (cfg_addr_i == ADDR_PSC);
  assign is_per  = (cfg_addr_i == ADDR_PER);
  assign is_en   = (cfg_addr_i == ADDR_EN);
  assign is_duty = (cfg_addr_i >= ADDR_DUTY0) && (cfg_addr_i < ADDR_DUTY0 + 4'(N_CH));

  // A zero period would stall the pwm counter, so it is rejected like a bad address.
  assign wr_bad = !(is_psc || is_per || is_en || is_duty) || (is_per && (cfg_data_i == '0));
  assign wr_ok  = wr_fire && !wr_bad;

  assign commit_load = (state_reg == COMMIT);

  // Sequencer FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_commit_i) begin
          // Nothing running means there is no period to protect: load right away.
          state_next = (en_reg == '0) ? COMMIT : PENDING;
        end
      end
      PENDING: begin
        if (period_end_i) begin
          state_next = COMMIT;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= wr_fire && wr_bad;
    end
  end

  // Shadow register writes (only possible in IDLE, so shadows are stable through COMMIT)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc_sh_reg <= '0;
      per_sh_reg <= '0;
      en_sh_reg  <= '0;
    end else if (wr_ok) begin
      if (is_psc) psc_sh_reg <= cfg_data_i[PSC_W-1:0];
      if (is_per) per_sh_reg <= cfg_data_i;
      if (is_en)  en_sh_reg  <= cfg_data_i[N_CH-1:0];
    end
  end

  // Live register load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc_reg <= '0;
      per_reg <= '0;
      en_reg  <= '0;
    end else if (commit_load) begin
      psc_reg <= psc_sh_reg;
      per_reg <= per_sh_reg;
      en_reg  <= en_sh_reg;
    end
  end

  // Per-channel duty shadow, clamp and live/ramp register
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] duty_sh_reg;
    logic [CNT_W-1:0] duty_clamped;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        duty_sh_reg <= '0;
      end else if (wr_ok && (cfg_addr_i == ADDR_DUTY0 + 4'(gi))) begin
        duty_sh_reg <= cfg_data_i;
      end
    end

    // Clamp only the value being loaded; the shadow keeps what software wrote.
    assign duty_clamped = (duty_sh_reg > per_sh_reg) ? per_sh_reg : duty_sh_reg;

    pwm_duty_ramp #(
      .CNT_W     (CNT_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_duty_ramp (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (commit_load),
      .load_val_i (duty_clamped),
      .load_en_i  (en_sh_reg[gi]),
      .en_i       (en_reg[gi]),
      .step_i     (period_end_i),
      .duty_o     (duty_cycle_o[gi*CNT_W +: CNT_W]),
      .busy_o     (ramp_busy[gi])
    );
  end

  assign enable_o     = en_reg;
  assign prescaler_o  = psc_reg;
  assign pwm_period_o = per_reg;
  assign busy_o       = (state_reg == PENDING) || (ramp_busy != '0);
  assign err_o        = err_reg;

endmodule : pwm_ctrl

// File: tb/tb_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_ctrl
// Self-checking bench for pwm_ctrl: directed transactions, a behavioural model
// compared against every output on each falling clock edge, plus hand-computed
// literal expectations at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_pwm_ctrl;

  localparam int N_CH      = 3;
  localparam int CNT_W     = 16;
  localparam int PSC_W     = 8;
  localparam int RAMP_STEP = 10;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  cfg_valid_i = 1'b0;
  logic                  cfg_ready_o;
  logic [3:0]            cfg_addr_i = '0;
  logic [CNT_W-1:0]      cfg_data_i = '0;
  logic                  cfg_commit_i = 1'b0;
  logic                  period_end_i = 1'b0;
  logic [N_CH-1:0]       enable_o;
  logic [PSC_W-1:0]      prescaler_o;
  logic [CNT_W-1:0]      pwm_period_o;
  logic [N_CH*CNT_W-1:0] duty_cycle_o;
  logic                  busy_o;
  logic                  err_o;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ctrl #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .PSC_W     (PSC_W),
    .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_commit_i (cfg_commit_i),
    .period_end_i (period_end_i),
    .enable_o     (enable_o),
    .prescaler_o  (prescaler_o),
    .pwm_period_o (pwm_period_o),
    .duty_cycle_o (duty_cycle_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int duty_of(input int ch);
    logic [CNT_W-1:0] v;
    v = duty_cycle_o[ch*CNT_W +: CNT_W];
    return int'(v);
  endfunction

  // -------------------------------------------------------------------------
  // Behavioural model: shadow values, live values, and two flags describing
  // where an accepted commit stands (waiting for a boundary / loading now).
  // -------------------------------------------------------------------------
  int s_psc = 0, s_per = 0, s_en = 0;
  int s_duty [N_CH];
  int m_psc = 0, m_per = 0, m_en = 0;
  int m_duty [N_CH];
  int m_tgt  [N_CH];
  bit m_wait = 0, m_load = 0, m_err = 0;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      s_duty[i] = 0; m_duty[i] = 0; m_tgt[i] = 0;
    end
  end

  function automatic int model_busy();
    int b;
    b = m_wait ? 1 : 0;
`ifdef PWM_CTRL_RAMP_EN
    for (int i = 0; i < N_CH; i++) begin
      if (((m_en >> i) & 1) == 1 && m_duty[i] != m_tgt[i]) b = 1;
    end
`endif
    return b;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_psc = 0; s_per = 0; s_en = 0;
      m_psc = 0; m_per = 0; m_en = 0;
      m_wait = 0; m_load = 0; m_err = 0;
      for (int i = 0; i < N_CH; i++) begin
        s_duty[i] = 0; m_duty[i] = 0; m_tgt[i] = 0;
      end
    end else begin
      m_err = 0;
      if (m_load) begin
        m_load = 0;
        m_psc  = s_psc;
        m_per  = s_per;
        m_en   = s_en;
        for (int i = 0; i < N_CH; i++) begin
          int v;
          v = (s_duty[i] > s_per) ? s_per : s_duty[i];
`ifdef PWM_CTRL_RAMP_EN
          m_tgt[i] = v;
          if (((s_en >> i) & 1) == 0) m_duty[i] = v;
`else
          m_duty[i] = v;
`endif
        end
      end else begin
`ifdef PWM_CTRL_RAMP_EN
        if (period_end_i) begin
          for (int i = 0; i < N_CH; i++) begin
            if (((m_en >> i) & 1) == 1) begin
              if (m_duty[i] < m_tgt[i])
                m_duty[i] = (m_duty[i] + RAMP_STEP > m_tgt[i]) ? m_tgt[i] : m_duty[i] + RAMP_STEP;
              else if (m_duty[i] > m_tgt[i])
                m_duty[i] = (m_duty[i] - RAMP_STEP < m_tgt[i]) ? m_tgt[i] : m_duty[i] - RAMP_STEP;
            end
          end
        end
`endif
        if (m_wait) begin
          if (period_end_i) begin
            m_wait = 0;
            m_load = 1;
          end
        end else begin
          if (cfg_valid_i) begin
            int a, d;
            a = int'(cfg_addr_i);
            d = int'(cfg_data_i);
            if (a == 0) s_psc = d & 255;
            else if (a == 1 && d != 0) s_per = d;
            else if (a == 2) s_en = d & 7;
            else if (a >= 3 && a < 3 + N_CH) s_duty[a-3] = d;
            else m_err = 1;
          end
          if (cfg_commit_i) begin
            if (m_en == 0) m_load = 1;
            else m_wait = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("enable_o", int'(enable_o), m_en);
    check("prescaler_o", int'(prescaler_o), m_psc);
    check("pwm_period_o", int'(pwm_period_o), m_per);
    for (int i = 0; i < N_CH; i++) begin
      check($sformatf("duty_ch%0d", i), duty_of(i), m_duty[i]);
    end
    check("cfg_ready_o", int'(cfg_ready_o), (m_wait || m_load) ? 0 : 1);
    check("busy_o", int'(busy_o), model_busy());
    check("err_o", int'(err_o), m_err ? 1 : 0);
  end

  // -------------------------------------------------------------------------
  // Transactions (inputs change 2 time units after a rising edge)
  // -------------------------------------------------------------------------
  task automatic do_write(input int a, input int d, input bit with_commit);
    @(posedge clk); #2;
    cfg_valid_i  = 1'b1;
    cfg_addr_i   = a[3:0];
    cfg_data_i   = d[CNT_W-1:0];
    cfg_commit_i = with_commit;
    @(posedge clk); #2;
    cfg_valid_i  = 1'b0;
    cfg_commit_i = 1'b0;
    $display("write addr=%0d data=%0d commit=%0d", a, d, with_commit);
  endtask

  task automatic do_commit();
    @(posedge clk); #2;
    cfg_commit_i = 1'b1;
    @(posedge clk); #2;
    cfg_commit_i = 1'b0;
    $display("commit request");
  endtask

  task automatic pulse_pe();
    @(posedge clk); #2;
    period_end_i = 1'b1;
    @(posedge clk); #2;
    period_end_i = 1'b0;
    $display("period_end pulse");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0t, expected < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset enable_o", int'(enable_o), 0);
    check("reset period", int'(pwm_period_o), 0);
    check("reset ready", int'(cfg_ready_o), 1);
    check("reset busy", int'(busy_o), 0);
    check("reset err", int'(err_o), 0);
    @(posedge clk); #2;
    rstn = 1'b1;
    $display("reset released");

    // 1: configure and commit with all channels off -> loads one edge later
    do_write(1, 100, 1'b0);
    do_write(3, 25, 1'b0);
    do_write(2, 1, 1'b0);
    do_commit();
    @(negedge clk);
    check("t1 period before load", int'(pwm_period_o), 0);
    check("t1 busy in commit", int'(busy_o), 0);
    @(negedge clk);
    check("t1 period", int'(pwm_period_o), 100);
    check("t1 enable", int'(enable_o), 1);
`ifndef PWM_CTRL_RAMP_EN
    check("t1 duty0", duty_of(0), 25);
`endif
    check("t1 busy", int'(busy_o), 0);

    // 2: channel running -> commit waits for period end
    do_write(4, 60, 1'b0);
    do_commit();
    idle(2);
    do_commit();  // ignored while pending
    @(negedge clk);
    check("t2 busy pending", int'(busy_o), 1);
    check("t2 ready pending", int'(cfg_ready_o), 0);
    check("t2 duty1 pending", duty_of(1), 0);
    pulse_pe();
    @(negedge clk);
    check("t2 duty1 commit cycle", duty_of(1), 0);
    @(negedge clk);
`ifndef PWM_CTRL_RAMP_EN
    check("t2 duty1 loaded", duty_of(1), 60);
`endif
    check("t2 ready back", int'(cfg_ready_o), 1);

    // 3: rejected writes
    do_write(9, 5, 1'b0);
    @(negedge clk);
    check("t3 err bad addr", int'(err_o), 1);
    @(negedge clk);
    check("t3 err clears", int'(err_o), 0);
    do_write(1, 0, 1'b0);
    @(negedge clk);
    check("t3 err zero period", int'(err_o), 1);
    @(negedge clk);
    check("t3 err clears 2", int'(err_o), 0);
    do_commit();
    pulse_pe();
    idle(2);
    check("t3 period unchanged", int'(pwm_period_o), 100);

    // 4: duty clamp at commit, shadow keeps the written value
    do_write(1, 50, 1'b0);
    do_write(5, 80, 1'b0);
    do_commit();
    pulse_pe();
    idle(2);
    check("t4 period 50", int'(pwm_period_o), 50);
`ifndef PWM_CTRL_RAMP_EN
    check("t4 duty2 clamped", duty_of(2), 50);
`endif
    do_write(1, 100, 1'b0);
    do_commit();
    pulse_pe();
    idle(2);
`ifndef PWM_CTRL_RAMP_EN
    check("t4 duty2 from shadow", duty_of(2), 80);
`endif

    // 5: asynchronous reset while a commit is pending
    do_write(3, 7, 1'b0);
    do_commit();
    @(posedge clk); #3;
    check("t5 busy before reset", int'(busy_o), 1);
    rstn = 1'b0;
    #1;
    check("t5 enable in reset", int'(enable_o), 0);
    check("t5 period in reset", int'(pwm_period_o), 0);
    check("t5 duty0 in reset", duty_of(0), 0);
    check("t5 busy in reset", int'(busy_o), 0);
    check("t5 ready in reset", int'(cfg_ready_o), 1);
    $display("async reset asserted while pending");
    @(posedge clk); #2;
    rstn = 1'b1;
    pulse_pe();
    idle(2);
    check("t5 no stale commit", int'(pwm_period_o), 0);
    // write and commit in the same cycle: the write is part of the commit
    do_write(1, 10, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t5 write+commit period", int'(pwm_period_o), 10);

`ifdef PWM_CTRL_RAMP_EN
    // 6: ramp 20 -> 45 with step 10
    do_write(1, 100, 1'b0);
    do_write(3, 20, 1'b0);
    do_commit();           // channel off: duty jumps to 20
    idle(2);
    do_write(2, 1, 1'b0);
    do_commit();           // still off live: direct load, target 20
    idle(2);
    check("t6 start duty0", duty_of(0), 20);
    do_write(3, 45, 1'b0);
    do_commit();
    pulse_pe();
    idle(1);
    check("t6 after load duty0", duty_of(0), 20);
    check("t6 busy ramping", int'(busy_o), 1);
    pulse_pe();
    @(negedge clk);
    check("t6 step1", duty_of(0), 30);
    pulse_pe();
    @(negedge clk);
    check("t6 step2", duty_of(0), 40);
    pulse_pe();
    @(negedge clk);
    check("t6 step3", duty_of(0), 45);
    check("t6 busy done", int'(busy_o), 0);
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_ctrl
